// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle CPU control unit.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ADDI    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b000;

endpackage

// File: rtl/ctrl_decoder.sv
// Opcode decoder: instruction class, ALU operation and ALU operand select.
module ctrl_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] instr_class,
    output logic [2:0] alu_control,
    output logic       alu_src
);

    // Unknown opcodes fall through to the illegal class with a harmless add.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        alu_control = ALU_ADD;
        alu_src     = 1'b0;
        case (opcode)
            OP_ADD: begin
                instr_class = CLS_RTYPE;
                alu_control = ALU_ADD;
            end
            OP_SUB: begin
                instr_class = CLS_RTYPE;
                alu_control = ALU_SUB;
            end
            OP_SLL: begin
                instr_class = CLS_RTYPE;
                alu_control = ALU_SLL;
            end
            OP_AND: begin
                instr_class = CLS_RTYPE;
                alu_control = ALU_AND;
            end
            OP_ADDI: begin
                instr_class = CLS_ADDI;
                alu_src     = 1'b1;
            end
            OP_LW: begin
                instr_class = CLS_LOAD;
                alu_src     = 1'b1;
            end
            OP_SW: begin
                instr_class = CLS_STORE;
                alu_src     = 1'b1;
            end
            OP_BEQ: begin
                instr_class = CLS_BRANCH;
                alu_control = ALU_SUB;
            end
            OP_HALT: begin
                instr_class = CLS_HALT;
            end
            default: begin
                instr_class = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with memory-wait timeout and bus-error halt.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        zero_flag,
    output logic        pc_write,
    output logic        pc_branch,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        flag_aluSrc,
    output logic [2:0]  alu_control_out,
    output logic        halted,
    output logic        bus_error,
    output logic        illegal_op,
    output logic [2:0]  state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_next;
    logic [3:0]        op_latched;
    logic              bus_err_q;
    logic              bus_err_set;
    logic              timeout;

    logic [3:0]        dec_opcode;
    logic [2:0]        dec_class;
    logic [2:0]        dec_alu;
    logic              dec_src;

    logic              pc_write_c;
    logic              pc_branch_c;
    logic              ir_write_c;
    logic              mem_read_c;
    logic              mem_write_c;
    logic              reg_write_c;
    logic              mem_to_reg_c;
    logic              alu_src_c;
    logic [2:0]        alu_c;
    logic              halted_c;
    logic              illegal_c;

    // Register operand fields belong to the datapath, not the controller.
    logic              unused_fields;
    assign unused_fields = ^instr[11:0];

    // DECODE classifies the fresh IR; later states see only the latched opcode.
    assign dec_opcode = (state == DECODE) ? instr[15:12] : op_latched;

    ctrl_decoder u_decoder (
        .opcode      (dec_opcode),
        .instr_class (dec_class),
        .alu_control (dec_alu),
        .alu_src     (dec_src)
    );

    // The final unanswered cycle is the one that would bring the count to the limit.
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State, wait counter, latched opcode and sticky bus-error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            op_latched <= OP_ADD;
            bus_err_q  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state == DECODE) begin
                op_latched <= instr[15:12];
            end
            if (bus_err_set) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Count consecutive stalled handshake cycles; any completion or state change clears it.
    always_comb begin
        wait_cnt_next = '0;
        if ((state == FETCH || state == MEM) && !mem_ready && state_next == state) begin
            if (wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                wait_cnt_next = wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt_next = wait_cnt;
            end
        end
    end

    // Next-state and raw strobe generation before the reset gate.
    always_comb begin
        state_next   = state;
        bus_err_set  = 1'b0;
        pc_write_c   = 1'b0;
        pc_branch_c  = 1'b0;
        ir_write_c   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_c    = 1'b0;
        alu_c        = ALU_AND;
        halted_c     = 1'b0;
        illegal_c    = 1'b0;
        case (state)
            FETCH: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    bus_err_set = 1'b1;
                    state_next  = HALT;
                end
            end
            DECODE: begin
                if (dec_class == CLS_HALT) begin
                    state_next = HALT;
                end else if (dec_class == CLS_ILLEGAL) begin
                    illegal_c  = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                alu_c     = dec_alu;
                alu_src_c = dec_src;
                if (dec_class == CLS_BRANCH) begin
                    pc_write_c  = zero_flag;
                    pc_branch_c = zero_flag;
                    state_next  = FETCH;
                end else if (dec_class == CLS_LOAD || dec_class == CLS_STORE) begin
                    state_next = MEM;
                end else if (dec_class == CLS_RTYPE || dec_class == CLS_ADDI) begin
                    state_next = WRITEBACK;
                end else begin
                    state_next = FETCH;
                end
            end
            MEM: begin
                alu_c       = dec_alu;
                alu_src_c   = dec_src;
                mem_read_c  = (dec_class == CLS_LOAD);
                mem_write_c = (dec_class != CLS_LOAD);
                if (mem_ready) begin
                    state_next = (dec_class == CLS_LOAD) ? WRITEBACK : FETCH;
                end else if (timeout) begin
                    bus_err_set = 1'b1;
                    state_next  = HALT;
                end
            end
            WRITEBACK: begin
                alu_c        = dec_alu;
                alu_src_c    = dec_src;
                reg_write_c  = 1'b1;
                mem_to_reg_c = (dec_class == CLS_LOAD);
                state_next   = FETCH;
            end
            HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign pc_write        = pc_write_c   & ~reset;
    assign pc_branch       = pc_branch_c  & ~reset;
    assign ir_write        = ir_write_c   & ~reset;
    assign mem_read        = mem_read_c   & ~reset;
    assign mem_write       = mem_write_c  & ~reset;
    assign reg_write       = reg_write_c  & ~reset;
    assign mem_to_reg      = mem_to_reg_c & ~reset;
    assign flag_aluSrc     = alu_src_c    & ~reset;
    assign alu_control_out = reset ? 3'b000 : alu_c;
    assign halted          = halted_c     & ~reset;
    assign illegal_op      = illegal_c    & ~reset;
    assign bus_error       = bus_err_q & (state == HALT) & ~reset;
    assign state_dbg       = reset ? 3'b000 : state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-cycle outputs queued at drive time.
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        zero_flag = 1'b0;
    logic        pc_write, pc_branch, ir_write, mem_read, mem_write;
    logic        reg_write, mem_to_reg, flag_aluSrc, halted, bus_error, illegal_op;
    logic [2:0]  alu_control_out, state_dbg;
    logic [16:0] obs;

    localparam logic [10:0] B_SRC  = 11'h400;
    localparam logic [10:0] B_MR   = 11'h200;
    localparam logic [10:0] B_MW   = 11'h100;
    localparam logic [10:0] B_IRW  = 11'h080;
    localparam logic [10:0] B_PCW  = 11'h040;
    localparam logic [10:0] B_PCB  = 11'h020;
    localparam logic [10:0] B_RW   = 11'h010;
    localparam logic [10:0] B_M2R  = 11'h008;
    localparam logic [10:0] B_HLT  = 11'h004;
    localparam logic [10:0] B_BERR = 11'h002;
    localparam logic [10:0] B_ILL  = 11'h001;
    localparam logic [10:0] NONE   = 11'h000;

    localparam logic [15:0] I_ADD  = 16'h0123;
    localparam logic [15:0] I_LW   = 16'h5213;
    localparam logic [15:0] I_SW   = 16'h6345;
    localparam logic [15:0] I_BEQ  = 16'h7120;
    localparam logic [15:0] I_ILL  = 16'hA123;
    localparam logic [15:0] I_HALT = 16'hF000;
    localparam logic [15:0] I_JUNK = 16'h3FFF;

    typedef struct {
        logic [16:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0]  ops  [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic [2:0]  alus [4] = '{3'b110, 3'b011, 3'b000, 3'b010};
    logic [10:0] srcs [4] = '{11'h000, 11'h000, 11'h000, 11'h400};

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr           (instr),
        .mem_ready       (mem_ready),
        .zero_flag       (zero_flag),
        .pc_write        (pc_write),
        .pc_branch       (pc_branch),
        .ir_write        (ir_write),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .reg_write       (reg_write),
        .mem_to_reg      (mem_to_reg),
        .flag_aluSrc     (flag_aluSrc),
        .alu_control_out (alu_control_out),
        .halted          (halted),
        .bus_error       (bus_error),
        .illegal_op      (illegal_op),
        .state_dbg       (state_dbg)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    assign obs = {state_dbg, alu_control_out, flag_aluSrc, mem_read, mem_write, ir_write,
                  pc_write, pc_branch, reg_write, mem_to_reg, halted, bus_error, illegal_op};

    function automatic logic [16:0] ev(input state_t st, input logic [2:0] alu, input logic [10:0] fl);
        return {st, alu, fl};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic [15:0] ins,
                                 input logic rdy, input logic zf, input logic [16:0] expv);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        instr     = ins;
        mem_ready = rdy;
        zero_flag = zf;
        e.val = expv;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Compare the oldest expectation once the cycle's combinational outputs have settled.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, 32'(obs), 32'(e.val));
        end
    end

    // Hard stop in case the stimulus sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus("reset", 1'b1, I_ADD, 1'b1, 1'b0, ev(FETCH, 3'b000, NONE));

        applyStimulus("add_fetch",  1'b0, I_ADD, 1'b1, 1'b0, ev(FETCH, 3'b000, B_MR | B_IRW | B_PCW));
        applyStimulus("add_decode", 1'b0, I_ADD, 1'b1, 1'b0, ev(DECODE, 3'b000, NONE));
        applyStimulus("add_exec",   1'b0, I_ADD, 1'b1, 1'b0, ev(EXECUTE, 3'b010, NONE));
        applyStimulus("add_wb",     1'b0, I_ADD, 1'b1, 1'b0, ev(WRITEBACK, 3'b010, B_RW));

        for (int i = 0; i < 4; i++) begin
            applyStimulus("op_fetch",  1'b0, {ops[i], 12'h345}, 1'b1, 1'b0, ev(FETCH, 3'b000, B_MR | B_IRW | B_PCW));
            applyStimulus("op_decode", 1'b0, {ops[i], 12'h345}, 1'b1, 1'b0, ev(DECODE, 3'b000, NONE));
            applyStimulus("op_exec",   1'b0, I_JUNK, 1'b1, 1'b0, ev(EXECUTE, alus[i], srcs[i]));
            applyStimulus("op_wb",     1'b0, I_JUNK, 1'b1, 1'b0, ev(WRITEBACK, alus[i], srcs[i] | B_RW));
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus("lw_fetch_wait", 1'b0, I_LW, 1'b0, 1'b0, ev(FETCH, 3'b000, B_MR));
        end
        applyStimulus("lw_fetch_last", 1'b0, I_LW, 1'b1, 1'b0, ev(FETCH, 3'b000, B_MR | B_IRW | B_PCW));
        applyStimulus("lw_decode",     1'b0, I_LW, 1'b0, 1'b0, ev(DECODE, 3'b000, NONE));
        applyStimulus("lw_exec",       1'b0, I_JUNK, 1'b1, 1'b0, ev(EXECUTE, 3'b010, B_SRC));
        for (int i = 0; i < 3; i++) begin
            applyStimulus("lw_mem_wait", 1'b0, I_JUNK, 1'b0, 1'b0, ev(MEM, 3'b010, B_SRC | B_MR));
        end
        applyStimulus("lw_mem_done", 1'b0, I_JUNK, 1'b1, 1'b0, ev(MEM, 3'b010, B_SRC | B_MR));
        applyStimulus("lw_wb",       1'b0, I_JUNK, 1'b1, 1'b0, ev(WRITEBACK, 3'b010, B_SRC | B_RW | B_M2R));

        applyStimulus("beq1_fetch",  1'b0, I_BEQ, 1'b1, 1'b1, ev(FETCH, 3'b000, B_MR | B_IRW | B_PCW));
        applyStimulus("beq1_decode", 1'b0, I_BEQ, 1'b1, 1'b1, ev(DECODE, 3'b000, NONE));
        applyStimulus("beq1_exec",   1'b0, I_BEQ, 1'b1, 1'b1, ev(EXECUTE, 3'b110, B_PCW | B_PCB));
        applyStimulus("beq0_fetch",  1'b0, I_BEQ, 1'b1, 1'b1, ev(FETCH, 3'b000, B_MR | B_IRW | B_PCW));
        applyStimulus("beq0_decode", 1'b0, I_BEQ, 1'b1, 1'b0, ev(DECODE, 3'b000, NONE));
        applyStimulus("beq0_exec",   1'b0, I_BEQ, 1'b1, 1'b0, ev(EXECUTE, 3'b110, NONE));

        applyStimulus("sw_fetch",  1'b0, I_SW, 1'b1, 1'b0, ev(FETCH, 3'b000, B_MR | B_IRW | B_PCW));
        applyStimulus("sw_decode", 1'b0, I_SW, 1'b1, 1'b0, ev(DECODE, 3'b000, NONE));
        applyStimulus("sw_exec",   1'b0, I_SW, 1'b1, 1'b0, ev(EXECUTE, 3'b010, B_SRC));
        applyStimulus("sw_mem",    1'b0, I_SW, 1'b1, 1'b0, ev(MEM, 3'b010, B_SRC | B_MW));

        applyStimulus("ill_fetch",  1'b0, I_ILL, 1'b1, 1'b0, ev(FETCH, 3'b000, B_MR | B_IRW | B_PCW));
        applyStimulus("ill_decode", 1'b0, I_ILL, 1'b1, 1'b0, ev(DECODE, 3'b000, B_ILL));
        applyStimulus("ill_return", 1'b0, I_ILL, 1'b0, 1'b0, ev(FETCH, 3'b000, B_MR));

        applyStimulus("swr_fetch",    1'b0, I_SW, 1'b1, 1'b0, ev(FETCH, 3'b000, B_MR | B_IRW | B_PCW));
        applyStimulus("swr_decode",   1'b0, I_SW, 1'b1, 1'b0, ev(DECODE, 3'b000, NONE));
        applyStimulus("swr_exec",     1'b0, I_SW, 1'b0, 1'b0, ev(EXECUTE, 3'b010, B_SRC));
        applyStimulus("swr_mem_wait", 1'b0, I_SW, 1'b0, 1'b0, ev(MEM, 3'b010, B_SRC | B_MW));
        applyStimulus("swr_mem_wait", 1'b0, I_SW, 1'b0, 1'b0, ev(MEM, 3'b010, B_SRC | B_MW));
        applyStimulus("swr_reset",    1'b1, I_SW, 1'b1, 1'b0, ev(FETCH, 3'b000, NONE));
        applyStimulus("swr_after",    1'b0, I_SW, 1'b0, 1'b0, ev(FETCH, 3'b000, B_MR));

        applyStimulus("halt_fetch",  1'b0, I_HALT, 1'b1, 1'b0, ev(FETCH, 3'b000, B_MR | B_IRW | B_PCW));
        applyStimulus("halt_decode", 1'b0, I_HALT, 1'b1, 1'b0, ev(DECODE, 3'b000, NONE));
        for (int i = 0; i < 3; i++) begin
            applyStimulus("halt_hold", 1'b0, I_ADD, 1'b1, 1'b0, ev(HALT, 3'b000, B_HLT));
        end
        applyStimulus("halt_reset", 1'b1, I_ADD, 1'b0, 1'b0, ev(FETCH, 3'b000, NONE));

        for (int i = 0; i < 4; i++) begin
            applyStimulus("to_fetch_wait", 1'b0, I_ADD, 1'b0, 1'b0, ev(FETCH, 3'b000, B_MR));
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("to_halt", 1'b0, I_ADD, 1'b1, 1'b0, ev(HALT, 3'b000, B_HLT | B_BERR));
        end
        applyStimulus("to_reset", 1'b1, I_ADD, 1'b1, 1'b0, ev(FETCH, 3'b000, NONE));
        applyStimulus("to_after", 1'b0, I_ADD, 1'b0, 1'b0, ev(FETCH, 3'b000, B_MR));

        @(negedge clk);
        #4;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
